// File: rtl/exe_stage_pkg.sv
// Shared widths and encodings for the execute stage: ALU commands, shift types
// and forwarding selects.
package exe_stage_pkg;

    localparam int WORD_WIDTH            = 32;
    localparam int SHIFTER_OPERAND_WIDTH = 12;
    localparam int SIGNED_IMM_WIDTH      = 24;

    typedef enum logic [3:0] {
        ALU_MOV = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_ADC = 4'b0011,
        ALU_SUB = 4'b0100,
        ALU_SBC = 4'b0101,
        ALU_AND = 4'b0110,
        ALU_ORR = 4'b0111,
        ALU_EOR = 4'b1000,
        ALU_MVN = 4'b1001
    } alu_cmd_e;

    typedef enum logic [1:0] {
        SHIFT_LSL = 2'b00,
        SHIFT_LSR = 2'b01,
        SHIFT_ASR = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_type_e;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;

endpackage

// File: rtl/exe_stage_val2_generator.sv
// Second ALU operand: rotated 8-bit immediate, zero-extended 12-bit memory
// offset, or shifted register operand.
module val2_generator
    import exe_stage_pkg::*;
(
    input  logic                             imm,
    input  logic                             mem_access,
    input  logic [SHIFTER_OPERAND_WIDTH-1:0] shifter_operand,
    input  logic [WORD_WIDTH-1:0]            val_rm,
    output logic [WORD_WIDTH-1:0]            val2
);

    logic [2*WORD_WIDTH-1:0] imm_rot;
    logic [2*WORD_WIDTH-1:0] rm_rot;
    logic [WORD_WIDTH-1:0]   imm_word;
    logic [4:0]              imm_amt;
    logic [4:0]              sh_amt;
    shift_type_e             sh_type;

    assign imm_word = {{(WORD_WIDTH-8){1'b0}}, shifter_operand[7:0]};
    assign imm_amt  = {shifter_operand[11:8], 1'b0};
    assign sh_amt   = shifter_operand[11:7];
    assign sh_type  = shift_type_e'(shifter_operand[6:5]);

    // Rotates are done by shifting a doubled word and keeping the low half.
    assign imm_rot = {imm_word, imm_word} >> imm_amt;
    assign rm_rot  = {val_rm, val_rm} >> sh_amt;

    always_comb begin
        val2 = '0;
        if (imm) begin
            val2 = imm_rot[WORD_WIDTH-1:0];
        end else if (mem_access) begin
            val2 = {{(WORD_WIDTH-SHIFTER_OPERAND_WIDTH){1'b0}}, shifter_operand};
        end else begin
            unique case (sh_type)
                SHIFT_LSL: val2 = val_rm << sh_amt;
                SHIFT_LSR: val2 = val_rm >> sh_amt;
                SHIFT_ASR: val2 = $signed(val_rm) >>> sh_amt;
                SHIFT_ROR: val2 = rm_rot[WORD_WIDTH-1:0];
                default:   val2 = val_rm;
            endcase
        end
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand select, Val2 generation, ALU, NZCV register, branch
// target and the EX/MEM pipeline register. Define FORWARDING_EN to mux Rn/Rm.
module exe_stage
    import exe_stage_pkg::*;
#(
    parameter int N = WORD_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             freeze,
    input  logic [3:0]                       exe_cmd,
    input  logic                             mem_read_in,
    input  logic                             mem_write_in,
    input  logic                             wb_en_in,
    input  logic                             imm,
    input  logic                             b_in,
    input  logic                             status_update,
    input  logic [3:0]                       dst_in,
    input  logic [N-1:0]                     pc_in,
    input  logic [N-1:0]                     val_rn,
    input  logic [N-1:0]                     val_rm,
    input  logic [SHIFTER_OPERAND_WIDTH-1:0] shifter_operand,
    input  logic [SIGNED_IMM_WIDTH-1:0]      signed_imm24,
    input  logic [1:0]                       sel_src1,
    input  logic [1:0]                       sel_src2,
    input  logic [N-1:0]                     fwd_mem_val,
    input  logic [N-1:0]                     fwd_wb_val,
    output logic                             branch_taken,
    output logic [N-1:0]                     branch_addr,
    output logic [3:0]                       status_out,
    output logic [N-1:0]                     alu_result_out,
    output logic [N-1:0]                     store_val_out,
    output logic [3:0]                       dst_out,
    output logic                             mem_read_out,
    output logic                             mem_write_out,
    output logic                             wb_en_out
);

    logic [N-1:0] src1;
    logic [N-1:0] src2;
    logic [N-1:0] val2;
    logic [N-1:0] op_b;
    logic         cin;
    logic [N:0]   sum;
    logic [N-1:0] result;
    logic         c_new;
    logic         v_new;
    logic         flags_valid;
    logic [N-1:0] branch_off;

`ifdef FORWARDING_EN
    always_comb begin
        unique case (sel_src1)
            FWD_MEM: src1 = fwd_mem_val;
            FWD_WB:  src1 = fwd_wb_val;
            default: src1 = val_rn;
        endcase
        unique case (sel_src2)
            FWD_MEM: src2 = fwd_mem_val;
            FWD_WB:  src2 = fwd_wb_val;
            default: src2 = val_rm;
        endcase
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{sel_src1, sel_src2, fwd_mem_val, fwd_wb_val};
    assign src1 = val_rn;
    assign src2 = val_rm;
`endif

    val2_generator u_val2 (
        .imm             (imm),
        .mem_access      (mem_read_in | mem_write_in),
        .shifter_operand (shifter_operand),
        .val_rm          (src2),
        .val2            (val2)
    );

    // One shared adder; subtraction is Rn + ~Val2 + cin so C means "no borrow".
    always_comb begin
        op_b = val2;
        cin  = 1'b0;
        unique case (exe_cmd)
            ALU_ADC: cin = status_out[1];
            ALU_SUB: begin op_b = ~val2; cin = 1'b1;          end
            ALU_SBC: begin op_b = ~val2; cin = status_out[1]; end
            default: ;
        endcase
    end

    assign sum = {1'b0, src1} + {1'b0, op_b} + {{N{1'b0}}, cin};

    always_comb begin
        result      = '0;
        c_new       = status_out[1];
        v_new       = status_out[0];
        flags_valid = 1'b1;
        unique case (exe_cmd)
            ALU_MOV: result = val2;
            ALU_MVN: result = ~val2;
            ALU_AND: result = src1 & val2;
            ALU_ORR: result = src1 | val2;
            ALU_EOR: result = src1 ^ val2;
            ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC: begin
                result = sum[N-1:0];
                c_new  = sum[N];
                v_new  = (src1[N-1] == op_b[N-1]) && (sum[N-1] != src1[N-1]);
            end
            default: flags_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_out <= '0;
        end else if (status_update && !freeze && flags_valid) begin
            status_out <= {result[N-1], (result == '0), c_new, v_new};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_result_out <= '0;
            store_val_out  <= '0;
            dst_out        <= '0;
            mem_read_out   <= 1'b0;
            mem_write_out  <= 1'b0;
            wb_en_out      <= 1'b0;
        end else if (!freeze) begin
            alu_result_out <= result;
            store_val_out  <= src2;
            dst_out        <= dst_in;
            mem_read_out   <= mem_read_in;
            mem_write_out  <= mem_write_in;
            wb_en_out      <= wb_en_in;
        end
    end

    assign branch_off   = {{(N-SIGNED_IMM_WIDTH){signed_imm24[SIGNED_IMM_WIDTH-1]}}, signed_imm24};
    assign branch_addr  = pc_in + (branch_off << 2);
    assign branch_taken = b_in;

endmodule

// File: tb/tb_exe_stage.sv
// Directed testbench for exe_stage; checks ALU, flags, shifter, freeze, reset,
// branch and (when FORWARDING_EN is defined) operand forwarding.
module tb_exe_stage;
    import exe_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic [3:0]  exe_cmd;
    logic        mem_read_in, mem_write_in, wb_en_in;
    logic        imm, b_in, status_update;
    logic [3:0]  dst_in;
    logic [31:0] pc_in, val_rn, val_rm;
    logic [11:0] shifter_operand;
    logic [23:0] signed_imm24;
    logic [1:0]  sel_src1, sel_src2;
    logic [31:0] fwd_mem_val, fwd_wb_val;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [3:0]  status_out;
    logic [31:0] alu_result_out, store_val_out;
    logic [3:0]  dst_out;
    logic        mem_read_out, mem_write_out, wb_en_out;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    exe_stage dut (
        .clk(clk), .rst(rst), .freeze(freeze), .exe_cmd(exe_cmd),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .wb_en_in(wb_en_in),
        .imm(imm), .b_in(b_in), .status_update(status_update), .dst_in(dst_in),
        .pc_in(pc_in), .val_rn(val_rn), .val_rm(val_rm),
        .shifter_operand(shifter_operand), .signed_imm24(signed_imm24),
        .sel_src1(sel_src1), .sel_src2(sel_src2),
        .fwd_mem_val(fwd_mem_val), .fwd_wb_val(fwd_wb_val),
        .branch_taken(branch_taken), .branch_addr(branch_addr),
        .status_out(status_out), .alu_result_out(alu_result_out),
        .store_val_out(store_val_out), .dst_out(dst_out),
        .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
        .wb_en_out(wb_en_out)
    );

    task automatic clear_inputs();
        freeze = 0; exe_cmd = 4'b0000; mem_read_in = 0; mem_write_in = 0;
        wb_en_in = 0; imm = 0; b_in = 0; status_update = 0; dst_in = 0;
        pc_in = 0; val_rn = 0; val_rm = 0; shifter_operand = 0; signed_imm24 = 0;
        sel_src1 = 0; sel_src2 = 0; fwd_mem_val = 0; fwd_wb_val = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one ALU operation and clock it through the EX/MEM register.
    task automatic do_op(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                         input logic im, input logic [11:0] so, input logic s);
        exe_cmd = cmd; val_rn = rn; val_rm = rm; imm = im; shifter_operand = so;
        status_update = s;
        step();
    endtask

    task automatic test_reset();
        rst = 1;
        clear_inputs();
        step();
        total++;
        if ({alu_result_out, store_val_out, dst_out, mem_read_out, mem_write_out, wb_en_out, status_out} !== '0)
            $display("FAIL reset: result=%h store=%h dst=%h ctl=%b%b%b nzcv=%b, want all 0",
                     alu_result_out, store_val_out, dst_out, mem_read_out, mem_write_out, wb_en_out, status_out);
        else passed++;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_add();
        wb_en_in = 1; dst_in = 4'd3;
        do_op(ALU_ADD, 32'd5, 32'd0, 1'b1, 12'h0FF, 1'b0);
        total++;
        if (alu_result_out !== 32'h104) $display("FAIL add_result: got %h want 00000104", alu_result_out);
        else passed++;
        total++;
        if (status_out !== 4'b0000) $display("FAIL add_status_s0: got %b want 0000", status_out);
        else passed++;
        total++;
        if (dst_out !== 4'd3 || wb_en_out !== 1'b1) $display("FAIL add_ctl: dst=%h wb=%b want 3 1", dst_out, wb_en_out);
        else passed++;
    endtask

    task automatic test_mov_rotate();
        do_op(ALU_MOV, 32'd0, 32'd0, 1'b1, 12'h1FF, 1'b1);
        total++;
        if (alu_result_out !== 32'hC000003F) $display("FAIL mov_rot: got %h want c000003f", alu_result_out);
        else passed++;
        total++;
        if (status_out !== 4'b1000) $display("FAIL mov_flags: got %b want 1000", status_out);
        else passed++;
    endtask

    task automatic test_cmp();
        wb_en_in = 0;
        do_op(ALU_SUB, 32'd3, 32'd0, 1'b1, 12'h003, 1'b1);
        total++;
        if (status_out !== 4'b0110 || wb_en_out !== 1'b0)
            $display("FAIL cmp: nzcv=%b wb=%b want 0110 0", status_out, wb_en_out);
        else passed++;
    endtask

    task automatic test_adc();
        do_op(ALU_ADC, 32'hFFFFFFFF, 32'd0, 1'b1, 12'h000, 1'b1);
        total++;
        if (alu_result_out !== 32'd0 || status_out !== 4'b0110)
            $display("FAIL adc: result=%h nzcv=%b want 00000000 0110", alu_result_out, status_out);
        else passed++;
    endtask

    task automatic test_overflow_and_logic();
        // 0x80000000 - 1: signed overflow, no borrow
        do_op(ALU_SUB, 32'h80000000, 32'd0, 1'b1, 12'h001, 1'b1);
        total++;
        if (alu_result_out !== 32'h7FFFFFFF || status_out !== 4'b0011)
            $display("FAIL sub_ovf: result=%h nzcv=%b want 7fffffff 0011", alu_result_out, status_out);
        else passed++;
        do_op(ALU_MVN, 32'd0, 32'd0, 1'b1, 12'h000, 1'b1);
        total++;
        if (alu_result_out !== 32'hFFFFFFFF || status_out !== 4'b1011)
            $display("FAIL mvn_keep_cv: result=%h nzcv=%b want ffffffff 1011", alu_result_out, status_out);
        else passed++;
        do_op(ALU_EOR, 32'hF0F0F0F0, 32'd0, 1'b1, 12'h0F0, 1'b1);
        total++;
        if (alu_result_out !== 32'hF0F0F000 || status_out !== 4'b1011)
            $display("FAIL eor: result=%h nzcv=%b want f0f0f000 1011", alu_result_out, status_out);
        else passed++;
        do_op(4'b0000, 32'd9, 32'd9, 1'b1, 12'h009, 1'b1);
        total++;
        if (alu_result_out !== 32'd0 || status_out !== 4'b1011)
            $display("FAIL invalid_cmd: result=%h nzcv=%b want 00000000 1011", alu_result_out, status_out);
        else passed++;
        // SBC with C=1 behaves as plain subtraction: 10-3=7
        do_op(ALU_SBC, 32'd10, 32'd0, 1'b1, 12'h003, 1'b1);
        total++;
        if (alu_result_out !== 32'd7 || status_out !== 4'b0010)
            $display("FAIL sbc: result=%h nzcv=%b want 00000007 0010", alu_result_out, status_out);
        else passed++;
    endtask

    task automatic test_shifts();
        logic [11:0] so_tab  [5] = '{12'h200, 12'h220, 12'h240, 12'h260, 12'h060};
        logic [31:0] exp_tab [5] = '{32'h00000010, 32'h08000000, 32'hF8000000, 32'h18000000, 32'h80000001};
        for (int i = 0; i < 5; i++) begin
            do_op(ALU_MOV, 32'd0, 32'h80000001, 1'b0, so_tab[i], 1'b0);
            total++;
            if (alu_result_out !== exp_tab[i])
                $display("FAIL shift_%0d: got %h want %h", i, alu_result_out, exp_tab[i]);
            else passed++;
        end
        mem_read_in = 1;
        do_op(ALU_ADD, 32'h1000, 32'hDEADBEEF, 1'b0, 12'hABC, 1'b0);
        total++;
        if (alu_result_out !== 32'h1ABC || mem_read_out !== 1'b1 || store_val_out !== 32'hDEADBEEF)
            $display("FAIL ldr_addr: result=%h mr=%b store=%h want 00001abc 1 deadbeef",
                     alu_result_out, mem_read_out, store_val_out);
        else passed++;
        mem_read_in = 0;
    endtask

    task automatic test_freeze();
        do_op(ALU_ADD, 32'd10, 32'd0, 1'b1, 12'h001, 1'b1);
        total++;
        if (alu_result_out !== 32'd11 || status_out !== 4'b0000)
            $display("FAIL pre_freeze: result=%h nzcv=%b want 0000000b 0000", alu_result_out, status_out);
        else passed++;
        freeze = 1;
        for (int i = 0; i < 3; i++) begin
            wb_en_in = ~wb_en_in;
            do_op(ALU_SUB, 32'd0, 32'(i), 1'b1, 12'(i + 5), 1'b1);
            total++;
            if (alu_result_out !== 32'd11 || status_out !== 4'b0000)
                $display("FAIL freeze_hold_%0d: result=%h nzcv=%b want 0000000b 0000",
                         i, alu_result_out, status_out);
            else passed++;
        end
        freeze = 0;
        do_op(ALU_ADD, 32'd1, 32'd0, 1'b1, 12'h001, 1'b0);
        total++;
        if (alu_result_out !== 32'd2) $display("FAIL unfreeze: got %h want 00000002", alu_result_out);
        else passed++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        rst = 1;
        #1;
        total++;
        if ({alu_result_out, store_val_out, dst_out, mem_read_out, mem_write_out, wb_en_out, status_out} !== '0)
            $display("FAIL reset_mid: result=%h nzcv=%b want 0", alu_result_out, status_out);
        else passed++;
        @(negedge clk);
        rst = 0;
        do_op(ALU_ADD, 32'd20, 32'd0, 1'b1, 12'h002, 1'b0);
        total++;
        if (alu_result_out !== 32'd22) $display("FAIL post_reset: got %h want 00000016", alu_result_out);
        else passed++;
    endtask

    task automatic test_branch();
        b_in = 1; pc_in = 32'h100; signed_imm24 = 24'hFFFFFE; freeze = 1;
        #1;
        total++;
        if (branch_taken !== 1'b1 || branch_addr !== 32'hF8)
            $display("FAIL branch: taken=%b addr=%h want 1 000000f8", branch_taken, branch_addr);
        else passed++;
        pc_in = 32'hFFFFFFFC; signed_imm24 = 24'h000001;
        #1;
        total++;
        if (branch_addr !== 32'h0) $display("FAIL branch_wrap: got %h want 00000000", branch_addr);
        else passed++;
        b_in = 0;
        #1;
        total++;
        if (branch_taken !== 1'b0) $display("FAIL branch_clear: got %b want 0", branch_taken);
        else passed++;
        freeze = 0;
    endtask

    task automatic test_forwarding();
        sel_src1 = FWD_MEM; fwd_mem_val = 32'd7; fwd_wb_val = 32'd100;
        sel_src2 = FWD_WB; mem_write_in = 1;
        do_op(ALU_ADD, 32'd2, 32'h55, 1'b1, 12'h001, 1'b0);
`ifdef FORWARDING_EN
        total++;
        if (alu_result_out !== 32'd8 || store_val_out !== 32'd100)
            $display("FAIL fwd: result=%h store=%h want 00000008 00000064", alu_result_out, store_val_out);
        else passed++;
`else
        total++;
        if (alu_result_out !== 32'd3 || store_val_out !== 32'h55)
            $display("FAIL fwd_ignored: result=%h store=%h want 00000003 00000055", alu_result_out, store_val_out);
        else passed++;
`endif
        mem_write_in = 0; sel_src1 = 0; sel_src2 = 0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_mov_rotate();
        test_cmp();
        test_adc();
        test_overflow_and_logic();
        test_shifts();
        test_freeze();
        test_reset_mid();
        test_branch();
        test_forwarding();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
